// File: rtl/duck_motion.sv
// Duck sprite vertical motion: debounced jump/duck buttons drive a frame-stepped
// GROUND / AIR / DUCK state machine with simple gravity and fast-fall.
module duck_motion #(
  parameter int CORDW           = 10,
  parameter int GROUND_Y        = 150,
  parameter int JUMP_V0         = 12,
  parameter int GRAVITY         = 1,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                    board_clk,
  input  logic                    Reset,
  input  logic                    frame,
  input  logic                    btn_up,
  input  logic                    btn_down,
  output logic signed [CORDW-1:0] duck_y,
  output logic [1:0]              state,
  output logic                    airborne,
  output logic                    ducking
);

  localparam int YW = CORDW + 1;
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic signed [YW-1:0] GY_EXT = YW'(GROUND_Y);
  localparam logic signed [YW-1:0] Y_MIN  = YW'(-(2 ** (CORDW - 1)));
  localparam logic signed [CORDW-1:0] GY  = CORDW'(GROUND_Y);
  localparam logic signed [7:0] V0        = 8'(JUMP_V0);
  localparam logic signed [7:0] G1        = 8'(GRAVITY);
  localparam logic signed [7:0] G2        = 8'(2 * GRAVITY);

  typedef enum logic [1:0] {
    GROUND = 2'b00,
    AIR    = 2'b01,
    DUCK   = 2'b10,
    BAD    = 2'b11
  } motion_t;

  logic [1:0]    raw;
  logic [1:0]    sync1, sync2, db;
  logic [CW-1:0] cnt [2];

  assign raw = {btn_down, btn_up};

  // Index 0 is the jump button, index 1 the duck button.
  for (genvar b = 0; b < 2; b++) begin : g_btn
    always_ff @(posedge board_clk or posedge Reset) begin
      if (Reset) begin
        sync1[b] <= 1'b0;
        sync2[b] <= 1'b0;
        db[b]    <= 1'b0;
        cnt[b]   <= '0;
      end else begin
        sync1[b] <= raw[b];
        sync2[b] <= sync1[b];
        if (sync2[b] == db[b]) begin
          cnt[b] <= '0;
        end else if (cnt[b] == CNT_MAX) begin
          db[b]  <= sync2[b];
          cnt[b] <= '0;
        end else begin
          cnt[b] <= cnt[b] + 1'b1;
        end
      end
    end
  end

  logic up_db, down_db, up_prev, up_rise;
  assign up_db   = db[0];
  assign down_db = db[1];
  assign up_rise = up_db & ~up_prev;

  motion_t                  cur, nxt;
  logic signed [7:0]        vel, vel_n;
  logic signed [CORDW-1:0]  y_n;
  logic                     jump_req, jump_req_n;
  logic signed [YW-1:0]     y_ext, vel_ext, y_sub;

  assign y_ext   = YW'(duck_y);
  assign vel_ext = YW'(vel);
  assign y_sub   = y_ext - vel_ext;

  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      cur      <= GROUND;
      vel      <= '0;
      duck_y   <= GY;
      jump_req <= 1'b0;
      up_prev  <= 1'b0;
    end else begin
      cur      <= nxt;
      vel      <= vel_n;
      duck_y   <= y_n;
      jump_req <= jump_req_n;
      up_prev  <= up_db;
    end
  end

  // A pending jump is only consumed when it was already set before this frame,
  // so an up edge landing on the frame cycle is taken on the next frame.
  always_comb begin
    nxt        = cur;
    vel_n      = vel;
    y_n        = duck_y;
    jump_req_n = jump_req;
    if (frame) begin
      case (cur)
        GROUND: begin
          if (jump_req) begin
            nxt        = AIR;
            vel_n      = V0;
            jump_req_n = 1'b0;
          end else if (down_db) begin
            nxt = DUCK;
          end
        end
        AIR: begin
          if (y_sub >= GY_EXT) begin
            nxt   = GROUND;
            y_n   = GY;
            vel_n = '0;
          end else begin
            if (y_sub < Y_MIN) y_n = Y_MIN[CORDW-1:0];
            else               y_n = y_sub[CORDW-1:0];
            vel_n = vel - (down_db ? G2 : G1);
          end
        end
        DUCK: begin
          y_n = GY;
          if (!down_db) nxt = GROUND;
        end
        default: begin
          nxt   = GROUND;
          y_n   = GY;
          vel_n = '0;
        end
      endcase
    end
    if (up_rise && cur == GROUND && !(frame && jump_req)) jump_req_n = 1'b1;
  end

  assign state    = cur;
  assign airborne = (cur == AIR);
  assign ducking  = (cur == DUCK);

endmodule
